// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out bit serializer with a one-word holding buffer so that
// consecutive words stream out with no idle bit between them.
module piso_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             bit_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_last,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             accept;
    logic [WIDTH-1:0] sreg_shifted;

    assign data_ready = !hold_full_q;
    assign accept     = data_valid && data_ready;

    // Shift toward whichever end drives dout.
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sreg_d  = data_in;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bit_en && (cnt_q == CntMax)) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        sreg_d      = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        // Zero-gap bypass: nothing buffered, so the new word goes straight in.
                        sreg_d = data_in;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (bit_en) begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + CntW'(1);
                    end
                    if (accept) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        dout = IDLE_BIT;
        if (state_q == StShift) begin
            dout = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end
    end

    assign dout_valid = (state_q == StShift) && bit_en;
    assign word_last  = dout_valid && (cnt_q == CntMax);
    assign busy       = (state_q == StShift) || hold_full_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: one MSB-first and one LSB-first instance.
module tb_piso_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       bit_en;
    logic       dout;
    logic       dout_valid;
    logic       word_last;
    logic       busy;

    logic [7:0] l_data_in;
    logic       l_data_valid;
    logic       l_data_ready;
    logic       l_bit_en;
    logic       l_dout;
    logic       l_dout_valid;
    logic       l_word_last;
    logic       l_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .bit_en     (bit_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .word_last  (word_last),
        .busy       (busy)
    );

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .data_in    (l_data_in),
        .data_valid (l_data_valid),
        .data_ready (l_data_ready),
        .bit_en     (l_bit_en),
        .dout       (l_dout),
        .dout_valid (l_dout_valid),
        .word_last  (l_word_last),
        .busy       (l_busy)
    );

    // Advance to 1 time unit past the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        data_in      = 8'h00;
        data_valid   = 1'b0;
        bit_en       = 1'b0;
        l_data_in    = 8'h00;
        l_data_valid = 1'b0;
        l_bit_en     = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({data_ready, dout, dout_valid, word_last, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs got rdy/dout/vld/last/busy=%b want 10000",
                     {data_ready, dout, dout_valid, word_last, busy});
        end
        checks++;
        if ({l_data_ready, l_dout, l_dout_valid, l_word_last, l_busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs_lsb got %b want 10000",
                     {l_data_ready, l_dout, l_dout_valid, l_word_last, l_busy});
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w = 8'hD0;
        @(negedge clk);
        step();
        data_in    = w;
        data_valid = 1'b1;
        bit_en     = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({dout, dout_valid, word_last} !== {w[7-i], 1'b1, (i == 7)}) begin
                errors++;
                $display("FAIL single_bit%0d got dout/vld/last=%b want %b", i,
                         {dout, dout_valid, word_last}, {w[7-i], 1'b1, (i == 7)});
            end
            step();
        end
        #1;
        checks++;
        if ({dout, dout_valid, busy, data_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL single_idle got dout/vld/busy/rdy=%b want 0001",
                     {dout, dout_valid, busy, data_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        logic        rdy_exp;
        s = {8'hA5, 8'h3C};
        step();
        data_in    = 8'hA5;
        data_valid = 1'b1;
        bit_en     = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                data_in    = 8'h3C;
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
            #1;
            rdy_exp = (k == 0) || (k >= 8);
            checks++;
            if ({dout, dout_valid, word_last, data_ready} !==
                {s[15-k], 1'b1, (k == 7 || k == 15), rdy_exp}) begin
                errors++;
                $display("FAIL b2b_bit%0d got dout/vld/last/rdy=%b want %b", k,
                         {dout, dout_valid, word_last, data_ready},
                         {s[15-k], 1'b1, (k == 7 || k == 15), rdy_exp});
            end
            step();
        end
        #1;
        checks++;
        if ({dout_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle got vld/busy=%b want 00", {dout_valid, busy});
        end
    endtask

    task automatic test_bit_en_gaps();
        logic [7:0] w;
        w = 8'h96;
        step();
        data_in    = w;
        data_valid = 1'b1;
        bit_en     = 1'b0;
        step();
        data_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            bit_en = (c % 2 == 1);
            #1;
            checks++;
            if ({dout, dout_valid, word_last} !== {w[7-c/2], (c % 2 == 1), (c == 15)}) begin
                errors++;
                $display("FAIL bit_en_c%0d got dout/vld/last=%b want %b", c,
                         {dout, dout_valid, word_last}, {w[7-c/2], (c % 2 == 1), (c == 15)});
            end
            step();
        end
        bit_en = 1'b1;
        #1;
        checks++;
        if ({dout_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bit_en_idle got vld/busy=%b want 00", {dout_valid, busy});
        end
    endtask

    task automatic test_mid_word_reset();
        logic [7:0] w;
        step();
        data_in    = 8'hFF;
        data_valid = 1'b1;
        bit_en     = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            // Park a word in the holding buffer so the reset has something to discard.
            data_in    = 8'h5A;
            data_valid = (c == 0);
            #1;
            checks++;
            if ({dout, dout_valid} !== 2'b11) begin
                errors++;
                $display("FAIL rst_pre_bit%0d got dout/vld=%b want 11", c, {dout, dout_valid});
            end
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({data_ready, busy, dout_valid, dout} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid got rdy/busy/vld/dout=%b want 1000",
                     {data_ready, busy, dout_valid, dout});
        end
        w          = 8'h81;
        data_in    = w;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({dout, dout_valid, word_last} !== {w[7-i], 1'b1, (i == 7)}) begin
                errors++;
                $display("FAIL rst_next_bit%0d got dout/vld/last=%b want %b", i,
                         {dout, dout_valid, word_last}, {w[7-i], 1'b1, (i == 7)});
            end
            step();
        end
        #1;
        checks++;
        if ({dout_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_after got vld/busy=%b want 00 (stale hold word)", {dout_valid, busy});
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'h0B;
        step();
        l_data_in    = w;
        l_data_valid = 1'b1;
        l_bit_en     = 1'b1;
        step();
        l_data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({l_dout, l_dout_valid, l_word_last} !== {w[i], 1'b1, (i == 7)}) begin
                errors++;
                $display("FAIL lsb_bit%0d got dout/vld/last=%b want %b", i,
                         {l_dout, l_dout_valid, l_word_last}, {w[i], 1'b1, (i == 7)});
            end
            step();
        end
        #1;
        checks++;
        if ({l_dout_valid, l_busy} !== 2'b00) begin
            errors++;
            $display("FAIL lsb_idle got vld/busy=%b want 00", {l_dout_valid, l_busy});
        end
    endtask

    task automatic test_hold_full_stall();
        logic [23:0] s;
        logic        rdy_exp;
        s = {8'h11, 8'h22, 8'h99};
        step();
        data_in    = 8'h11;
        data_valid = 1'b1;
        bit_en     = 1'b1;
        step();
        for (int k = 0; k < 24; k++) begin
            if (k == 0) begin
                data_in    = 8'h22;
                data_valid = 1'b1;
            end else if (k == 8) begin
                data_in    = 8'h99;
                data_valid = 1'b1;
            end else if (k < 16) begin
                // Junk presented while the buffer is full must never be taken.
                data_in    = 8'h30 + 8'(k);
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
            #1;
            rdy_exp = (k == 0) || (k == 8) || (k >= 16);
            checks++;
            if ({dout, dout_valid, word_last, data_ready} !==
                {s[23-k], 1'b1, (k % 8 == 7), rdy_exp}) begin
                errors++;
                $display("FAIL stall_bit%0d got dout/vld/last/rdy=%b want %b", k,
                         {dout, dout_valid, word_last, data_ready},
                         {s[23-k], 1'b1, (k % 8 == 7), rdy_exp});
            end
            step();
        end
        #1;
        checks++;
        if ({dout_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL stall_idle got vld/busy=%b want 00", {dout_valid, busy});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bit_en_gaps();
        test_mid_word_reset();
        test_lsb_first();
        test_hold_full_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
